tdm_seq_4ch: RTL and testbench
==============================

# tdm_seq_4ch

Sequencer for a 4-channel time-division link built from the team's `mux_4_1` and `demux_1_4` stages. It sits in front of the mux and behind the demux:
- On the transmit side it snapshots a 4-bit word, holds it on the mux data inputs, and steps the shared selector `S` through slots 0..3.
- On the receive side it collects each demux output bit in its slot and reassembles the word.

Externally, mux `F` drives demux `D` (loopback or a link), so a word entering `I_in` reappears on `O` one frame later.

## Interface
Parameters:
- `SLOT_CYCLES`, default 1: clock cycles per slot. Legal values ≥1. Slot counter width is `$clog2(SLOT_CYCLES)`, minimum 1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `en`, input, 1: run request. Low forces IDLE.
- `I_in`, input, 4: word to transmit. Sampled only at frame start.
- `I_hold`, output, 4: registered snapshot. Drives `mux_4_1.I`.
- `S`, output, 2: slot select. Drives `mux_4_1.S` and `demux_1_4.S`.
- `frame_sync`, output, 1: high during the first cycle of every frame.
- `f_in`, input, 4: `demux_1_4.f` outputs.
- `O`, output, 4: reassembled received word.
- `o_valid`, output, 1: one-cycle pulse when `O` is updated.

## Operation
- States:
  - IDLE: `S`=0, cycle counter=0, shadow=0.
  - RUN: frame in progress.
- IDLE, `en`=1 at an edge:
  - `I_hold`←`I_in`, `S`←0, cycle counter←0, `frame_sync`←1.
  - Move to RUN.
- RUN, `en`=0 at an edge (abort; highest priority after reset):
  - Go to IDLE, `S`←0, shadow←0.
  - No `o_valid`. `O` and `I_hold` keep their values.
- RUN, `en`=1, cycle counter < `SLOT_CYCLES`−1:
  - Cycle counter increments. `S` holds.
- RUN, `en`=1, cycle counter = `SLOT_CYCLES`−1 (last cycle of a slot):
  - shadow[`S`]←`f_in[S]`, cycle counter←0.
  - If `S`<3: `S`←`S`+1.
  - If `S`=3: `O`←{`f_in[3]`, shadow[2:0]}, `o_valid`←1, `S`←0 (wraps), `I_hold`←`I_in`, `frame_sync`←1. This starts the next frame back-to-back with no gap cycle.
- `frame_sync` and `o_valid` are 0 in every cycle not named above.
- `f_in` bits other than `f_in[S]` are ignored.

## Timing
- Reset (`rst_n`=0 at an edge, any state, including mid-frame):
  - State IDLE, `S`=0, `I_hold`=0, `O`=0, `o_valid`=0, `frame_sync`=0, counters and shadow 0.
  - Reset has priority over `en`.
- Frame length is exactly 4·`SLOT_CYCLES` cycles. `S`=k holds for `SLOT_CYCLES` consecutive cycles.
- Latency: `I_in` sampled at edge t0 → `o_valid`=1 and `O` valid in the cycle after edge t0+4·`SLOT_CYCLES`.
- `o_valid` and the next `frame_sync` rise on the same edge.
- Sampling point: `f_in` is sampled at the end of each slot, so external mux/demux paths have a full slot to settle.
- If `en` falls during the last cycle of slot 3, the frame is aborted: no `o_valid`, `O` unchanged.
- Continuous `en`=1 gives one `o_valid` per 4·`SLOT_CYCLES` cycles and never stalls.

## Test plan
All scenarios use external loopback (mux `F` → demux `D`) unless noted.
- Reset:
  - Stimulus: hold `rst_n`=0 for 2 cycles with `en`=1, `I_in`=4'hF.
  - Required: all outputs 0, `S`=0, no `frame_sync`.
- Single frame, `SLOT_CYCLES`=1:
  - Stimulus: `I_in`=4'b1010, raise `en` for 4 cycles, then drop it.
  - Required: `S` sequence 0,1,2,3; `frame_sync` high in the first cycle only; `o_valid` pulse with `O`=4'b1010 four cycles after start; IDLE afterwards.
- Back-to-back frames:
  - Stimulus: `en` held high; `I_in`=4'b1010, then 4'b0101 presented before the wrap.
  - Required: `O`=1010 then 0101, `o_valid` every 4 cycles, `S` wraps 3→0 with no gap cycle.
- `SLOT_CYCLES`=3:
  - Stimulus: `I_in`=4'b0110.
  - Required: each `S` value held 3 cycles; `o_valid` 12 cycles after start; `O`=4'b0110.
- Abort:
  - Stimulus: drop `en` while `S`=2.
  - Required: next cycle `S`=0 and IDLE; no `o_valid`; `O` keeps the previous word. A restart then delivers a full, correct frame.
- Reset mid-frame and selectivity:
  - Stimulus 1: assert `rst_n`=0 while `S`=1.
  - Required: outputs return to reset values; the prior partial word never appears on `O`.
  - Stimulus 2: force `f_in`=4'b1111 during slot 0 only, without loopback.
  - Required: `O`[0]=1 and the other bits come from their own slots.

Source files
------------

// File: rtl/tdm_seq_4ch.sv
// Slot sequencer for a 4-channel TDM link: snapshots a word for the mux, steps the shared
// selector through slots 0..3 and reassembles the demux outputs into a received word.
module tdm_seq_4ch #(
  parameter int unsigned SLOT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] I_in,
  output logic [3:0] I_hold,
  output logic [1:0] S,
  output logic       frame_sync,
  input  logic [3:0] f_in,
  output logic [3:0] O,
  output logic       o_valid
);

  localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic          state_q, state_d;
  logic [1:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [3:0]    i_hold_q, i_hold_d;
  logic [3:0]    o_q, o_d;
  logic          o_valid_q, o_valid_d;
  logic          frame_sync_q, frame_sync_d;
  logic          slot_end;

  assign slot_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    i_hold_d     = i_hold_q;
    o_d          = o_q;
    o_valid_d    = 1'b0;
    frame_sync_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_d      = 2'd0;
        cnt_d    = '0;
        shadow_d = 3'd0;
        if (en) begin
          i_hold_d     = I_in;
          frame_sync_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          // Abort: drop the partial word, keep O and I_hold as they were.
          state_d  = ST_IDLE;
          s_d      = 2'd0;
          cnt_d    = '0;
          shadow_d = 3'd0;
        end else if (!slot_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (s_q != 2'd3) begin
            shadow_d[s_q] = f_in[s_q];
            s_d           = s_q + 2'd1;
          end else begin
            // Last slot: publish the word and start the next frame with no gap.
            o_d          = {f_in[3], shadow_q};
            o_valid_d    = 1'b1;
            s_d          = 2'd0;
            i_hold_d     = I_in;
            frame_sync_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= 2'd0;
      cnt_q        <= '0;
      shadow_q     <= 3'd0;
      i_hold_q     <= 4'd0;
      o_q          <= 4'd0;
      o_valid_q    <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      i_hold_q     <= i_hold_d;
      o_q          <= o_d;
      o_valid_q    <= o_valid_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign I_hold     = i_hold_q;
  assign S          = s_q;
  assign frame_sync = frame_sync_q;
  assign O          = o_q;
  assign o_valid    = o_valid_q;

endmodule

// File: tb/tb_tdm_seq_4ch.sv
// Bench for tdm_seq_4ch: two instances (1 and 3 cycles per slot) with mux/demux loopback,
// checked every cycle against a frame-position model plus scripted literal checks.
module tb_tdm_seq_4ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en     [2];
  logic [3:0] i_in   [2];
  logic       ext    [2];
  logic [3:0] f_ext  [2];
  logic [3:0] i_hold_w [2];
  logic [1:0] s_w    [2];
  logic       fs_w   [2];
  logic [3:0] f_in_w [2];
  logic [3:0] o_w    [2];
  logic       ov_w   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Loopback: demux output S carries mux input I_hold[S], other demux outputs are 0.
  assign f_in_w[0] = ext[0] ? f_ext[0] : (4'(i_hold_w[0][s_w[0]]) << s_w[0]);
  assign f_in_w[1] = ext[1] ? f_ext[1] : (4'(i_hold_w[1][s_w[1]]) << s_w[1]);

  tdm_seq_4ch #(.SLOT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .I_in(i_in[0]), .I_hold(i_hold_w[0]),
    .S(s_w[0]), .frame_sync(fs_w[0]), .f_in(f_in_w[0]), .O(o_w[0]), .o_valid(ov_w[0])
  );

  tdm_seq_4ch #(.SLOT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .I_in(i_in[1]), .I_hold(i_hold_w[1]),
    .S(s_w[1]), .frame_sync(fs_w[1]), .f_in(f_in_w[1]), .O(o_w[1]), .o_valid(ov_w[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Model: position within the frame, snapshot word and bits collected so far.
  logic       m_run [2];
  int         m_pos [2];
  logic [3:0] m_hold[2];
  logic [3:0] m_o   [2];
  logic [3:0] m_rx  [2];
  logic       m_ov  [2];
  logic       m_fs  [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_pos[k] = 0; m_hold[k] = 4'd0; m_o[k] = 4'd0;
      m_rx[k] = 4'd0; m_ov[k] = 1'b0; m_fs[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int sc;
        int slot;
        logic fb;
        sc   = (k == 0) ? 1 : 3;
        slot = m_pos[k] / sc;
        fb   = ext[k] ? f_ext[k][slot] : m_hold[k][slot];
        m_ov[k] = 1'b0;
        m_fs[k] = 1'b0;
        if (!rst_n) begin
          m_run[k] = 1'b0; m_pos[k] = 0; m_hold[k] = 4'd0; m_o[k] = 4'd0; m_rx[k] = 4'd0;
        end else if (!m_run[k]) begin
          if (en[k]) begin
            m_hold[k] = i_in[k]; m_run[k] = 1'b1; m_pos[k] = 0; m_fs[k] = 1'b1;
          end
        end else if (!en[k]) begin
          m_run[k] = 1'b0; m_pos[k] = 0;
        end else begin
          if (m_pos[k] % sc == sc - 1) m_rx[k][slot] = fb;
          if (m_pos[k] == 4 * sc - 1) begin
            m_o[k] = m_rx[k]; m_ov[k] = 1'b1; m_fs[k] = 1'b1;
            m_hold[k] = i_in[k]; m_pos[k] = 0;
          end else begin
            m_pos[k]++;
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        int sc;
        sc = (k == 0) ? 1 : 3;
        chk("S", k, 32'(s_w[k]), m_run[k] ? 32'(m_pos[k] / sc) : 32'd0);
        chk("I_hold", k, 32'(i_hold_w[k]), 32'(m_hold[k]));
        chk("frame_sync", k, 32'(fs_w[k]), 32'(m_fs[k]));
        chk("o_valid", k, 32'(ov_w[k]), 32'(m_ov[k]));
        chk("O", k, 32'(o_w[k]), 32'(m_o[k]));
      end
    end
  end

  // Count edges until o_valid is seen; -1 if the budget expires.
  task automatic wait_ov(input int k, input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #2;
      if (ov_w[k]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic wait_s(input int k, input logic [1:0] val);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #2;
      if (s_w[k] == val) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_S", k, 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b1; i_in[k] = 4'hF; ext[k] = 1'b0; f_ext[k] = 4'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_S", k, 32'(s_w[k]), 32'd0);
      chk("rst_I_hold", k, 32'(i_hold_w[k]), 32'd0);
      chk("rst_O", k, 32'(o_w[k]), 32'd0);
      chk("rst_fs", k, 32'(fs_w[k]), 32'd0);
      chk("rst_ov", k, 32'(ov_w[k]), 32'd0);
      en[k] = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, one cycle per slot
    en[0] = 1'b1; i_in[0] = 4'b1010;
    wait_ov(0, 20, n);
    chk("single_latency", 0, 32'(n), 32'd5);
    chk("single_O", 0, 32'(o_w[0]), 32'b1010);
    chk("single_fs_with_ov", 0, 32'(fs_w[0]), 32'd1);
    @(negedge clk); en[0] = 1'b0;
    @(negedge clk);

    // Back-to-back frames
    en[0] = 1'b1; i_in[0] = 4'b1010;
    @(negedge clk); i_in[0] = 4'b0101;
    wait_ov(0, 20, n);
    chk("b2b_gap1", 0, 32'(n), 32'd4);
    chk("b2b_O1", 0, 32'(o_w[0]), 32'b1010);
    wait_ov(0, 20, n);
    chk("b2b_gap2", 0, 32'(n), 32'd4);
    chk("b2b_O2", 0, 32'(o_w[0]), 32'b0101);
    @(negedge clk); en[0] = 1'b0;
    @(negedge clk);

    // Three cycles per slot
    en[1] = 1'b1; i_in[1] = 4'b0110;
    wait_ov(1, 40, n);
    chk("sc3_latency", 1, 32'(n), 32'd13);
    chk("sc3_O", 1, 32'(o_w[1]), 32'b0110);
    @(negedge clk); en[1] = 1'b0;
    @(negedge clk);

    // Abort in slot 2, then restart
    en[0] = 1'b1; i_in[0] = 4'b1100;
    wait_s(0, 2'd2);
    @(negedge clk); en[0] = 1'b0;
    @(posedge clk); #2;
    chk("abort_S", 0, 32'(s_w[0]), 32'd0);
    chk("abort_ov", 0, 32'(ov_w[0]), 32'd0);
    chk("abort_O", 0, 32'(o_w[0]), 32'b0101);
    @(negedge clk); en[0] = 1'b1; i_in[0] = 4'b0011;
    wait_ov(0, 20, n);
    chk("restart_latency", 0, 32'(n), 32'd5);
    chk("restart_O", 0, 32'(o_w[0]), 32'b0011);
    @(negedge clk); en[0] = 1'b0;
    @(negedge clk);

    // Reset in slot 1
    en[0] = 1'b1; i_in[0] = 4'b1111;
    wait_s(0, 2'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #2;
    chk("midrst_O", 0, 32'(o_w[0]), 32'd0);
    chk("midrst_I_hold", 0, 32'(i_hold_w[0]), 32'd0);
    chk("midrst_S", 0, 32'(s_w[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1; en[0] = 1'b0;
    @(negedge clk);

    // Slot selectivity: all-ones only during slot 0, random elsewhere, no loopback
    ext[0] = 1'b1; en[0] = 1'b1; i_in[0] = 4'b0000;
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      f_ext[0] = (s_w[0] == 2'd0) ? 4'hF : 4'($urandom);
      @(posedge clk); #2;
      if (ov_w[0]) begin
        n = c;
        break;
      end
    end
    chk("sel_seen", 0, 32'(n > 0), 32'd1);
    chk("sel_O0", 0, 32'(o_w[0][0]), 32'd1);
    @(negedge clk); en[0] = 1'b0; ext[0] = 1'b0;
    @(negedge clk);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        en[k]    = ($urandom_range(0, 19) != 0);
        i_in[k]  = 4'($urandom);
        f_ext[k] = 4'($urandom);
        if ($urandom_range(0, 63) == 0) ext[k] = ~ext[k];
      end
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
